// File: rtl/fwd_sel_unit.sv
// Forwarding-select generator for the LC-3b EX-stage operand muxes.
// Tracks in-flight destination tags and raises load-use stalls.
module fwd_sel_unit #(
  parameter int REGW = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [REGW-1:0] id_sr1,
  input  logic            id_sr1_used,
  input  logic [REGW-1:0] id_sr2,
  input  logic            id_sr2_used,
  input  logic [REGW-1:0] id_dr,
  input  logic            id_wr_en,
  input  logic            id_is_load,
  input  logic            pipe_stall,
  input  logic            flush,
  output logic [1:0]      sr1_sel,
  output logic [1:0]      sr2_sel,
  output logic            hazard_stall
);

  typedef struct packed {
    logic            vld;
    logic [REGW-1:0] dr;
  } slot_t;

  localparam slot_t BUBBLE = '{vld: 1'b0, dr: '0};

  slot_t ex_q, mem_q, wb_q;
  logic  ex_ld_q;

  slot_t      id_slot;
  logic       ld_hit;
  logic       take;
  logic       load_bubble;
  logic [1:0] sel1_d, sel2_d;

  function automatic logic [1:0] pick(
    input logic            used,
    input logic [REGW-1:0] src,
    input slot_t           ex,
    input slot_t           mem,
    input slot_t           wb
  );
    logic [1:0] r;
    r = 2'b00;
    priority case (1'b1)
      used && ex.vld  && src == ex.dr:  r = 2'b01;
      used && mem.vld && src == mem.dr: r = 2'b10;
      used && wb.vld  && src == wb.dr:  r = 2'b11;
      default:                          r = 2'b00;
    endcase
    return r;
  endfunction

  always_comb begin
    ld_hit = 1'b0;
    if (ex_q.vld && ex_ld_q) begin
      ld_hit = (id_sr1_used && id_sr1 == ex_q.dr)
             | (id_sr2_used && id_sr2 == ex_q.dr);
    end
    hazard_stall = id_valid & ld_hit & ~flush;
  end

  // A load-use consumer never reaches EX while the load is still there.
  always_comb begin
    take        = id_valid & ~hazard_stall & ~flush;
    load_bubble = ~take;
    id_slot     = '{vld: id_wr_en, dr: id_dr};
    sel1_d      = pick(id_sr1_used, id_sr1, ex_q, mem_q, wb_q);
    sel2_d      = pick(id_sr2_used, id_sr2, ex_q, mem_q, wb_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q    <= BUBBLE;
      mem_q   <= BUBBLE;
      wb_q    <= BUBBLE;
      ex_ld_q <= 1'b0;
      sr1_sel <= 2'b00;
      sr2_sel <= 2'b00;
    end else if (!pipe_stall) begin
      wb_q  <= mem_q;
      mem_q <= flush ? BUBBLE : ex_q;
      if (load_bubble) begin
        ex_q    <= BUBBLE;
        ex_ld_q <= 1'b0;
        sr1_sel <= 2'b00;
        sr2_sel <= 2'b00;
      end else begin
        ex_q    <= id_slot;
        ex_ld_q <= id_is_load;
        sr1_sel <= sel1_d;
        sr2_sel <= sel2_d;
      end
    end
  end

endmodule

// File: tb/tb_fwd_sel_unit.sv
// Directed bench for fwd_sel_unit.
// Per-cycle vector table plus reset sequences.
module tb_fwd_sel_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [2:0] id_sr1;
  logic       id_sr1_used;
  logic [2:0] id_sr2;
  logic       id_sr2_used;
  logic [2:0] id_dr;
  logic       id_wr_en;
  logic       id_is_load;
  logic       pipe_stall;
  logic       flush;
  logic [1:0] sr1_sel;
  logic [1:0] sr2_sel;
  logic       hazard_stall;

  int n_tests = 0;
  int n_fail  = 0;

  fwd_sel_unit #(.REGW(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_sr1       (id_sr1),
    .id_sr1_used  (id_sr1_used),
    .id_sr2       (id_sr2),
    .id_sr2_used  (id_sr2_used),
    .id_dr        (id_dr),
    .id_wr_en     (id_wr_en),
    .id_is_load   (id_is_load),
    .pipe_stall   (pipe_stall),
    .flush        (flush),
    .sr1_sel      (sr1_sel),
    .sr2_sel      (sr2_sel),
    .hazard_stall (hazard_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       val;
    logic [2:0] s1;
    logic       u1;
    logic [2:0] s2;
    logic       u2;
    logic [2:0] dr;
    logic       we;
    logic       ld;
    logic       st;
    logic       fl;
    logic       hz;
    logic [1:0] e1;
    logic [1:0] e2;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(
    input logic val, input logic [2:0] s1, input logic u1,
    input logic [2:0] s2, input logic u2, input logic [2:0] dr,
    input logic we, input logic ld, input logic st, input logic fl,
    input logic hz, input logic [1:0] e1, input logic [1:0] e2);
    vec_t r;
    r.val = val; r.s1 = s1; r.u1 = u1; r.s2 = s2; r.u2 = u2;
    r.dr = dr; r.we = we; r.ld = ld; r.st = st; r.fl = fl;
    r.hz = hz; r.e1 = e1; r.e2 = e2;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [1:0] act, input logic [1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %b want %b", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    id_valid    = t.val;
    id_sr1      = t.s1;
    id_sr1_used = t.u1;
    id_sr2      = t.s2;
    id_sr2_used = t.u2;
    id_dr       = t.dr;
    id_wr_en    = t.we;
    id_is_load  = t.ld;
    pipe_stall  = t.st;
    flush       = t.fl;
  endtask

  initial begin
    // val s1 u1 s2 u2 dr we ld st fl | hz e1 e2
    tbl.push_back(v(1,0,1,0,1,1,1,0,0,0, 0,2'b00,2'b00)); // 0 ADD R1
    tbl.push_back(v(1,1,1,1,1,2,1,0,0,0, 0,2'b01,2'b01)); // 1 ADD R2<-R1,R1
    tbl.push_back(v(1,0,1,0,1,3,1,0,0,0, 0,2'b00,2'b00)); // 2 ADD R3
    tbl.push_back(v(1,0,1,0,0,7,1,0,0,0, 0,2'b00,2'b00)); // 3 unrelated
    tbl.push_back(v(1,5,1,3,1,0,1,0,0,0, 0,2'b00,2'b10)); // 4 AND uses R3
    tbl.push_back(v(1,5,1,5,1,3,1,0,0,0, 0,2'b00,2'b00)); // 5 ADD R3
    tbl.push_back(v(1,5,1,0,0,6,1,0,0,0, 0,2'b00,2'b00)); // 6
    tbl.push_back(v(1,5,1,0,0,6,1,0,0,0, 0,2'b00,2'b00)); // 7
    tbl.push_back(v(1,5,1,3,1,0,1,0,0,0, 0,2'b00,2'b11)); // 8 gap 2
    tbl.push_back(v(1,5,1,5,1,3,1,0,0,0, 0,2'b00,2'b00)); // 9 ADD R3
    tbl.push_back(v(1,5,1,0,0,6,1,0,0,0, 0,2'b00,2'b00)); // 10
    tbl.push_back(v(1,5,1,0,0,6,1,0,0,0, 0,2'b00,2'b00)); // 11
    tbl.push_back(v(1,5,1,0,0,6,1,0,0,0, 0,2'b00,2'b00)); // 12
    tbl.push_back(v(1,5,1,3,1,0,1,0,0,0, 0,2'b00,2'b00)); // 13 gap 3
    tbl.push_back(v(1,5,1,0,0,4,1,1,0,0, 0,2'b00,2'b00)); // 14 LDR R4
    tbl.push_back(v(1,4,1,7,1,2,1,0,0,0, 1,2'b00,2'b00)); // 15 stall
    tbl.push_back(v(1,4,1,7,1,2,1,0,0,0, 0,2'b10,2'b00)); // 16 from MEM
    tbl.push_back(v(1,5,1,0,0,6,1,0,0,0, 0,2'b00,2'b00)); // 17 ADD R6
    tbl.push_back(v(1,5,1,0,0,6,1,0,0,0, 0,2'b00,2'b00)); // 18 ADD R6
    tbl.push_back(v(1,6,1,6,1,1,1,0,0,0, 0,2'b01,2'b01)); // 19 youngest
    tbl.push_back(v(1,6,0,6,1,3,1,0,0,0, 0,2'b00,2'b10)); // 20 unused
    tbl.push_back(v(1,3,1,1,1,4,1,0,0,0, 0,2'b01,2'b10)); // 21
    tbl.push_back(v(1,4,1,3,1,2,1,0,1,0, 0,2'b01,2'b10)); // 22 frozen
    tbl.push_back(v(1,4,1,3,1,2,1,0,1,0, 0,2'b01,2'b10)); // 23
    tbl.push_back(v(1,4,1,3,1,2,1,0,1,0, 0,2'b01,2'b10)); // 24
    tbl.push_back(v(1,4,1,3,1,2,1,0,0,0, 0,2'b01,2'b10)); // 25 release
    tbl.push_back(v(1,5,1,0,0,7,1,1,0,0, 0,2'b00,2'b00)); // 26 LDR R7
    tbl.push_back(v(1,7,1,0,0,1,1,0,1,0, 1,2'b00,2'b00)); // 27 held haz
    tbl.push_back(v(1,7,1,0,0,1,1,0,1,0, 1,2'b00,2'b00)); // 28
    tbl.push_back(v(1,7,1,0,0,1,1,0,0,0, 1,2'b00,2'b00)); // 29 bubble
    tbl.push_back(v(1,7,1,0,0,1,1,0,0,0, 0,2'b10,2'b00)); // 30
    tbl.push_back(v(1,5,1,0,0,6,1,0,0,0, 0,2'b00,2'b00)); // 31 ADD R6
    tbl.push_back(v(1,5,1,0,0,1,1,0,0,0, 0,2'b00,2'b00)); // 32 ADD R1
    tbl.push_back(v(1,1,1,1,1,2,1,0,0,1, 0,2'b00,2'b00)); // 33 flush
    tbl.push_back(v(1,1,1,1,1,2,1,0,0,0, 0,2'b00,2'b00)); // 34 R1 gone
    tbl.push_back(v(1,5,1,0,0,3,1,1,0,0, 0,2'b00,2'b00)); // 35 LDR R3
    tbl.push_back(v(1,3,1,0,0,4,1,0,0,1, 0,2'b00,2'b00)); // 36 flush
    tbl.push_back(v(1,3,1,2,1,4,1,0,0,0, 0,2'b00,2'b11)); // 37 WB kept
    tbl.push_back(v(0,4,1,4,1,5,1,0,0,0, 0,2'b00,2'b00)); // 38 invalid
    tbl.push_back(v(1,4,1,0,0,1,1,1,0,0, 0,2'b10,2'b00)); // 39 LDR R1

    reset = 1'b1;
    drive(v(1,1,1,1,1,1,1,1,0,0, 0,2'b00,2'b00));
    for (int c = 0; c < 2; c++) begin
      id_valid    = 1'($urandom);
      id_sr1      = 3'($urandom);
      id_sr1_used = 1'($urandom);
      id_sr2      = 3'($urandom);
      id_sr2_used = 1'($urandom);
      id_dr       = 3'($urandom);
      id_wr_en    = 1'($urandom);
      id_is_load  = 1'($urandom);
      pipe_stall  = 1'($urandom);
      flush       = 1'($urandom);
      @(posedge clk);
      #1;
      chk("rst_sr1", -1, sr1_sel, 2'b00);
      chk("rst_sr2", -1, sr2_sel, 2'b00);
      chk("rst_haz", -1, {1'b0, hazard_stall}, 2'b00);
    end
    reset = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i]);
      #3;
      chk("hazard", i, {1'b0, hazard_stall}, {1'b0, tbl[i].hz});
      @(posedge clk);
      #1;
      chk("sr1_sel", i, sr1_sel, tbl[i].e1);
      chk("sr2_sel", i, sr2_sel, tbl[i].e2);
    end

    // Load R1 now in EX; consumer stalls under pipe_stall, then reset wins.
    drive(v(1,1,1,0,0,2,1,0,1,0, 0,2'b00,2'b00));
    #3;
    chk("pre_rst_haz", 100, {1'b0, hazard_stall}, 2'b01);
    @(posedge clk);
    #1;
    chk("pre_rst_sr1", 100, sr1_sel, 2'b10);
    reset = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    flush = 1'b0;
    #1;
    chk("mid_rst_haz", 101, {1'b0, hazard_stall}, 2'b00);
    chk("mid_rst_sr1", 101, sr1_sel, 2'b00);
    chk("mid_rst_sr2", 101, sr2_sel, 2'b00);
    pipe_stall = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_sr1", 102, sr1_sel, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
